// File: rtl/vector_sequencer.sv
// Multicycle controller that sequences the vector datapath (VRF, X1/X2, R2, T0-T3)
// for VLOAD, VSTORE and VADD. Outputs are Moore-decoded from state, cnt and the capture pipe.
module vector_sequencer #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       R2Sel,
  output logic       R2Ld,
  output logic       AddrSel,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] MemIn,
  output logic       X1Load,
  output logic       X2Load,
  output logic       VoutSel,
  output logic       T0Ld,
  output logic       T1Ld,
  output logic       T2Ld,
  output logic       T3Ld,
  output logic       VRFWrite,
  output logic [3:0] ostate
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_ADD   = 3'd5;
  localparam logic [2:0] S_WB    = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0] state_r;
  logic [2:0] state_nx_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nx_s;
  logic [1:0] op_r;
  logic       cap_vld_r [MEM_RD_LAT];
  logic [1:0] cap_idx_r [MEM_RD_LAT];
  logic       arr_vld_s;
  logic [1:0] arr_idx_s;
  logic       step_s;
  logic       add_s;

  assign arr_vld_s = cap_vld_r[MEM_RD_LAT-1] && ((state_r == S_RD) || (state_r == S_DRAIN));
  assign arr_idx_s = cap_idx_r[MEM_RD_LAT-1];

  // State, element counter, latched op and read-arrival pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 2'd0;
      op_r    <= 2'd0;
      for (int i = 0; i < MEM_RD_LAT; i++) begin
        cap_vld_r[i] <= 1'b0;
        cap_idx_r[i] <= 2'd0;
      end
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if ((state_r == S_IDLE) && start) begin
        op_r <= op;
      end
      cap_vld_r[0] <= (state_r == S_RD);
      cap_idx_r[0] <= cnt_r;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        cap_vld_r[i] <= cap_vld_r[i-1];
        cap_idx_r[i] <= cap_idx_r[i-1];
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (op == 2'b11) state_nx_s = S_ERR;
          else             state_nx_s = S_SETUP;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_nx_s = 2'd0;
        case (op_r)
          2'b00:   state_nx_s = S_RD;
          2'b01:   state_nx_s = S_WR;
          default: state_nx_s = S_ADD;
        endcase
      end
      S_RD: begin
        cnt_nx_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) state_nx_s = S_DRAIN;
        else               state_nx_s = S_RD;
      end
      S_DRAIN: begin
        // Wait for the last element to land in T0 before writing back
        if (arr_vld_s && (arr_idx_s == 2'd3)) state_nx_s = S_WB;
        else                                  state_nx_s = S_DRAIN;
      end
      S_WR: begin
        cnt_nx_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) state_nx_s = S_IDLE;
        else               state_nx_s = S_WR;
      end
      S_ADD:   state_nx_s = S_WB;
      S_WB:    state_nx_s = S_IDLE;
      S_ERR:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  assign step_s = ((state_r == S_RD) || (state_r == S_WR)) && (cnt_r != 2'd3);
  assign add_s  = (state_r == S_ADD);

  // Moore output decode
  always_comb begin
    busy     = (state_r != S_IDLE);
    done     = ((state_r == S_WR) && (cnt_r == 2'd3)) || (state_r == S_WB) || (state_r == S_ERR);
    illegal  = (state_r == S_ERR);
    R2Sel    = step_s;
    R2Ld     = step_s || (state_r == S_SETUP);
    AddrSel  = 1'b0;
    MemRead  = (state_r == S_RD);
    MemWrite = (state_r == S_WR);
    if (state_r == S_WR) MemIn = {1'b0, cnt_r};
    else                 MemIn = 3'b100;
    X1Load   = (state_r == S_SETUP);
    X2Load   = (state_r == S_SETUP);
    VoutSel  = arr_vld_s;
    T3Ld     = add_s || (arr_vld_s && (arr_idx_s == 2'd0));
    T2Ld     = add_s || (arr_vld_s && (arr_idx_s == 2'd1));
    T1Ld     = add_s || (arr_vld_s && (arr_idx_s == 2'd2));
    T0Ld     = add_s || (arr_vld_s && (arr_idx_s == 2'd3));
    VRFWrite = (state_r == S_WB);
    ostate   = {1'b0, state_r};
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: two sequencers (read latency 1 and 2) drive a shared behavioural
// datapath (R2, X1/X2, byte memory, T lanes, VRF write port) with hand-computed checks.
module tb_vector_sequencer;

  logic       clock;
  logic       reset;
  logic [1:0] start;
  logic [1:0] op;
  logic [1:0] busy, done, illegal, r2sel, r2ld, addrsel, memread, memwrite;
  logic [1:0] x1load, x2load, voutsel, t0ld, t1ld, t2ld, t3ld, vrfwrite;
  logic [2:0] memin  [2];
  logic [3:0] ostate [2];

  int n_cmp;
  int n_bad;

  vector_sequencer #(.MEM_RD_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .start(start[0]), .op(op),
    .busy(busy[0]), .done(done[0]), .illegal(illegal[0]),
    .R2Sel(r2sel[0]), .R2Ld(r2ld[0]), .AddrSel(addrsel[0]),
    .MemRead(memread[0]), .MemWrite(memwrite[0]), .MemIn(memin[0]),
    .X1Load(x1load[0]), .X2Load(x2load[0]), .VoutSel(voutsel[0]),
    .T0Ld(t0ld[0]), .T1Ld(t1ld[0]), .T2Ld(t2ld[0]), .T3Ld(t3ld[0]),
    .VRFWrite(vrfwrite[0]), .ostate(ostate[0])
  );

  vector_sequencer #(.MEM_RD_LAT(2)) u_lat2 (
    .clock(clock), .reset(reset), .start(start[1]), .op(op),
    .busy(busy[1]), .done(done[1]), .illegal(illegal[1]),
    .R2Sel(r2sel[1]), .R2Ld(r2ld[1]), .AddrSel(addrsel[1]),
    .MemRead(memread[1]), .MemWrite(memwrite[1]), .MemIn(memin[1]),
    .X1Load(x1load[1]), .X2Load(x2load[1]), .VoutSel(voutsel[1]),
    .T0Ld(t0ld[1]), .T1Ld(t1ld[1]), .T2Ld(t2ld[1]), .T3Ld(t3ld[1]),
    .VRFWrite(vrfwrite[1]), .ostate(ostate[1])
  );

  always #5 clock = ~clock;

  // Behavioural datapath; the idle sequencer's strobes are all 0 so they can be ORed
  int         sel;
  logic [7:0] rf_data2;
  logic [31:0] vdata1, vdata2;
  logic [7:0] r2, rd1, rd2, memwire;
  logic [7:0] mem [256];
  logic [7:0] t   [4];
  logic [31:0] x1, x2, vrf_wdata;
  int         vrf_we;

  assign memwire = (sel == 1) ? rd2 : rd1;

  always @(posedge clock) begin
    if (reset) begin
      mem[8'h20] <= 8'h11;
      mem[8'h21] <= 8'h22;
      mem[8'h22] <= 8'h33;
      mem[8'h23] <= 8'h44;
    end else begin
      if (|r2ld) r2 <= (|r2sel) ? r2 + 8'd1 : rf_data2;
      if (|x1load) x1 <= vdata1;
      if (|x2load) x2 <= vdata2;
      rd1 <= (|memread) ? mem[r2] : 8'h00;
      rd2 <= rd1;
      if (|memwrite) begin
        case (memin[sel])
          3'd0:    mem[r2] <= x1[31:24];
          3'd1:    mem[r2] <= x1[23:16];
          3'd2:    mem[r2] <= x1[15:8];
          3'd3:    mem[r2] <= x1[7:0];
          default: mem[r2] <= mem[r2];
        endcase
      end
      if (|t0ld) t[0] <= (|voutsel) ? memwire : x1[7:0]   + x2[7:0];
      if (|t1ld) t[1] <= (|voutsel) ? memwire : x1[15:8]  + x2[15:8];
      if (|t2ld) t[2] <= (|voutsel) ? memwire : x1[23:16] + x2[23:16];
      if (|t3ld) t[3] <= (|voutsel) ? memwire : x1[31:24] + x2[31:24];
      if (|vrfwrite) begin
        vrf_wdata <= {t[3], t[2], t[1], t[0]};
        vrf_we    <= vrf_we + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int         lat, vrf_cyc, viol, caps, dstrb, ill_cnt, we_base;
  logic [11:0] memin_seq;

  // Launch one op on sequencer s and watch it cycle by cycle until done (bounded)
  task automatic run_op(input int s, input logic [1:0] o, input int pulse_at, input string nm);
    lat = 0; vrf_cyc = 0; viol = 0; caps = 0; dstrb = 0; ill_cnt = 0; memin_seq = 12'h000;
    we_base = vrf_we;
    @(negedge clock); op = o; start[s] = 1'b1;
    @(negedge clock); start[s] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clock);
      if (c == pulse_at) begin
        start[s] = 1'b1;
        op = 2'b10;
      end else begin
        start[s] = 1'b0;
      end
      if (memread[s] && memwrite[s]) viol++;
      if (voutsel[s]) begin
        caps++;
        if ($countones({t0ld[s], t1ld[s], t2ld[s], t3ld[s]}) != 1) viol++;
      end
      if (memwrite[s]) memin_seq = {memin_seq[8:0], memin[s]};
      if (vrfwrite[s]) vrf_cyc = c;
      if (illegal[s]) ill_cnt++;
      if (r2ld[s] || memread[s] || memwrite[s] || x1load[s] || x2load[s] || voutsel[s] ||
          t0ld[s] || t1ld[s] || t2ld[s] || t3ld[s] || vrfwrite[s]) dstrb++;
      if (done[s]) begin
        lat = c;
        break;
      end
    end
    start[s] = 1'b0;
    @(negedge clock);
    check_eq({nm, "_done_width"}, {31'd0, done[s]}, 32'd0);
    check_eq({nm, "_idle_after"}, {31'd0, busy[s]}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; vrf_we = 0;
    clock = 1'b0; reset = 1'b1; start = 2'b00; op = 2'b00; sel = 0;
    rf_data2 = 8'h00; vdata1 = 32'h0; vdata2 = 32'h0;

    // Reset held with start asserted: both stay idle, all strobes low, MemIn = 100
    repeat (2) @(negedge clock);
    start = 2'b11;
    repeat (3) @(negedge clock);
    check_eq("rst_ostate0", {28'd0, ostate[0]}, 32'd0);
    check_eq("rst_ostate1", {28'd0, ostate[1]}, 32'd0);
    check_eq("rst_memin", {29'd0, memin[0]}, 32'd4);
    check_eq("rst_strobes", {16'd0, busy | done | illegal | r2sel | r2ld | addrsel | memread | memwrite,
                             x1load | x2load | voutsel | t0ld | t1ld | t2ld | t3ld | vrfwrite}, 32'd0);
    start = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // VLOAD, latency 1
    sel = 0; rf_data2 = 8'h20;
    run_op(0, 2'b00, 0, "vload1");
    check_eq("vload1_lat", lat, 32'd7);
    check_eq("vload1_vrf_cyc", vrf_cyc, 32'd7);
    check_eq("vload1_data", vrf_wdata, 32'h11223344);
    check_eq("vload1_r2", {24'd0, r2}, 32'h23);
    check_eq("vload1_viol", viol, 32'd0);
    check_eq("vload1_caps", caps, 32'd4);
    check_eq("vload1_we", vrf_we - we_base, 32'd1);

    // VSTORE with a stray start mid-operation
    vdata1 = 32'hA1B2C3D4; rf_data2 = 8'h40;
    run_op(0, 2'b01, 3, "vstore");
    check_eq("vstore_lat", lat, 32'd5);
    check_eq("vstore_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hA1B2C3D4);
    check_eq("vstore_memin", {20'd0, memin_seq}, 32'h053);
    check_eq("vstore_viol", viol, 32'd0);
    check_eq("vstore_we", vrf_we - we_base, 32'd0);

    // VADD with per-lane wrap
    vdata1 = 32'hFF017F80; vdata2 = 32'h01010101;
    run_op(0, 2'b10, 0, "vadd");
    check_eq("vadd_lat", lat, 32'd3);
    check_eq("vadd_data", vrf_wdata, 32'h00028081);
    check_eq("vadd_we", vrf_we - we_base, 32'd1);

    // Reserved op
    run_op(0, 2'b11, 0, "err");
    check_eq("err_lat", lat, 32'd1);
    check_eq("err_illegal", ill_cnt, 32'd1);
    check_eq("err_strobes", dstrb, 32'd0);

    // Reset during RD cnt=2 (cycle 4) clears outputs without a clock edge
    rf_data2 = 8'h20;
    @(negedge clock); op = 2'b00; start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("midrst_pre_state", {28'd0, ostate[0]}, 32'd2);
    reset = 1'b1;
    #1;
    check_eq("midrst_ostate", {28'd0, ostate[0]}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy[0]}, 32'd0);
    check_eq("midrst_memread", {31'd0, memread[0]}, 32'd0);
    check_eq("midrst_memin", {29'd0, memin[0]}, 32'd4);
    @(negedge clock);
    reset = 1'b0;

    vdata1 = 32'h12345678; vdata2 = 32'h11111111;
    run_op(0, 2'b10, 0, "vadd2");
    check_eq("vadd2_lat", lat, 32'd3);
    check_eq("vadd2_data", vrf_wdata, 32'h23456789);

    // VLOAD, latency 2
    sel = 1; rf_data2 = 8'h20;
    run_op(1, 2'b00, 0, "vload2");
    check_eq("vload2_lat", lat, 32'd8);
    check_eq("vload2_vrf_cyc", vrf_cyc, 32'd8);
    check_eq("vload2_data", vrf_wdata, 32'h11223344);
    check_eq("vload2_r2", {24'd0, r2}, 32'h23);
    check_eq("vload2_viol", viol, 32'd0);
    check_eq("vload2_caps", caps, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
